// File: rtl/kl_splitter_1by2.sv
// 1-to-2 KL bus address router: steers requests to the off-chip bridge (dn0)
// or the local port (dn1) and returns responses upstream in request order.
module kl_splitter_1by2 #(
  parameter logic [31:0] LOCAL_BASE = 32'h0200_0000,
  parameter logic [31:0] LOCAL_MASK = 32'hFF00_0000,
  parameter int          MAX_OUTST  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // upstream request
  input  logic [31:0]                    up_req_addr,
  input  logic                           up_req_wen,
  input  logic [63:0]                    up_req_wdata,
  input  logic [7:0]                     up_req_wmask,
  input  logic [2:0]                     up_req_size,
  input  logic [4:0]                     up_req_srcid,
  input  logic                           up_req_valid,
  output logic                           up_req_ready,
  // upstream response
  output logic [63:0]                    up_resp_rdata,
  output logic [2:0]                     up_resp_size,
  output logic [4:0]                     up_resp_dstid,
  output logic                           up_resp_valid,
  input  logic                           up_resp_ready,
  // dn0: off-chip bridge
  output logic [31:0]                    dn0_req_addr,
  output logic                           dn0_req_wen,
  output logic [63:0]                    dn0_req_wdata,
  output logic [7:0]                     dn0_req_wmask,
  output logic [2:0]                     dn0_req_size,
  output logic [4:0]                     dn0_req_srcid,
  output logic                           dn0_req_valid,
  input  logic                           dn0_req_ready,
  input  logic [63:0]                    dn0_resp_rdata,
  input  logic [2:0]                     dn0_resp_size,
  input  logic [4:0]                     dn0_resp_dstid,
  input  logic                           dn0_resp_valid,
  output logic                           dn0_resp_ready,
  // dn1: local window
  output logic [31:0]                    dn1_req_addr,
  output logic                           dn1_req_wen,
  output logic [63:0]                    dn1_req_wdata,
  output logic [7:0]                     dn1_req_wmask,
  output logic [2:0]                     dn1_req_size,
  output logic [4:0]                     dn1_req_srcid,
  output logic                           dn1_req_valid,
  input  logic                           dn1_req_ready,
  input  logic [63:0]                    dn1_resp_rdata,
  input  logic [2:0]                     dn1_resp_size,
  input  logic [4:0]                     dn1_resp_dstid,
  input  logic                           dn1_resp_valid,
  output logic                           dn1_resp_ready,
  // in-flight tracker state, for observation only
  output logic [$clog2(MAX_OUTST):0]     dbg_count,
  output logic [$clog2(MAX_OUTST)-1:0]   dbg_wr_ptr,
  output logic [$clog2(MAX_OUTST)-1:0]   dbg_rd_ptr
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are
  // both high; valid never depends on ready, and payload is only meaningful
  // while valid is high.

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          dst_q [MAX_OUTST];

  logic full;
  logic empty;
  logic sel;
  logic head;
  logic req_open;
  logic resp_open;
  logic push;
  logic pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign sel   = ((up_req_addr & LOCAL_MASK) == LOCAL_BASE);
  assign head  = dst_q[rd_ptr];

  // rst_n gates the combinational handshakes so nothing leaks out while in reset.
  assign req_open  = rst_n & ~full;
  assign resp_open = rst_n & ~empty;

  // Request path: payload fans out to both ports, valid only to the selected one.
  assign dn0_req_addr  = up_req_addr;
  assign dn0_req_wen   = up_req_wen;
  assign dn0_req_wdata = up_req_wdata;
  assign dn0_req_wmask = up_req_wmask;
  assign dn0_req_size  = up_req_size;
  assign dn0_req_srcid = up_req_srcid;
  assign dn1_req_addr  = up_req_addr;
  assign dn1_req_wen   = up_req_wen;
  assign dn1_req_wdata = up_req_wdata;
  assign dn1_req_wmask = up_req_wmask;
  assign dn1_req_size  = up_req_size;
  assign dn1_req_srcid = up_req_srcid;

  assign dn0_req_valid = up_req_valid & req_open & ~sel;
  assign dn1_req_valid = up_req_valid & req_open & sel;
  assign up_req_ready  = req_open & (sel ? dn1_req_ready : dn0_req_ready);
  assign push          = up_req_valid & up_req_ready;

  // Response path: only the port at the FIFO head may hand a response upstream;
  // the other port is backpressured until its entry reaches the head.
  assign up_resp_rdata  = head ? dn1_resp_rdata : dn0_resp_rdata;
  assign up_resp_size   = head ? dn1_resp_size  : dn0_resp_size;
  assign up_resp_dstid  = head ? dn1_resp_dstid : dn0_resp_dstid;
  assign up_resp_valid  = resp_open & (head ? dn1_resp_valid : dn0_resp_valid);
  assign dn0_resp_ready = resp_open & ~head & up_resp_ready;
  assign dn1_resp_ready = resp_open & head & up_resp_ready;
  assign pop            = up_resp_valid & up_resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < MAX_OUTST; i++) dst_q[i] <= 1'b0;
    end else begin
      if (push) begin
        dst_q[wr_ptr] <= sel;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dbg_count  = count;
  assign dbg_wr_ptr = wr_ptr;
  assign dbg_rd_ptr = rd_ptr;

endmodule

// File: tb/tb_kl_splitter_1by2.sv
// Directed bench for kl_splitter_1by2: routing vector table plus ordering,
// full, backpressure and async-reset sequences.
module tb_kl_splitter_1by2;

  logic        clk;
  logic        rst_n;
  logic [31:0] up_req_addr;
  logic        up_req_wen;
  logic [63:0] up_req_wdata;
  logic [7:0]  up_req_wmask;
  logic [2:0]  up_req_size;
  logic [4:0]  up_req_srcid;
  logic        up_req_valid;
  logic        up_req_ready;
  logic [63:0] up_resp_rdata;
  logic [2:0]  up_resp_size;
  logic [4:0]  up_resp_dstid;
  logic        up_resp_valid;
  logic        up_resp_ready;
  logic [31:0] dn0_req_addr, dn1_req_addr;
  logic        dn0_req_wen, dn1_req_wen;
  logic [63:0] dn0_req_wdata, dn1_req_wdata;
  logic [7:0]  dn0_req_wmask, dn1_req_wmask;
  logic [2:0]  dn0_req_size, dn1_req_size;
  logic [4:0]  dn0_req_srcid, dn1_req_srcid;
  logic        dn0_req_valid, dn1_req_valid;
  logic        dn0_req_ready, dn1_req_ready;
  logic [63:0] dn0_resp_rdata, dn1_resp_rdata;
  logic [2:0]  dn0_resp_size, dn1_resp_size;
  logic [4:0]  dn0_resp_dstid, dn1_resp_dstid;
  logic        dn0_resp_valid, dn1_resp_valid;
  logic        dn0_resp_ready, dn1_resp_ready;
  logic [2:0]  dbg_count;
  logic [1:0]  dbg_wr_ptr;
  logic [1:0]  dbg_rd_ptr;

  kl_splitter_1by2 dut (
    .clk(clk), .rst_n(rst_n),
    .up_req_addr(up_req_addr), .up_req_wen(up_req_wen), .up_req_wdata(up_req_wdata),
    .up_req_wmask(up_req_wmask), .up_req_size(up_req_size), .up_req_srcid(up_req_srcid),
    .up_req_valid(up_req_valid), .up_req_ready(up_req_ready),
    .up_resp_rdata(up_resp_rdata), .up_resp_size(up_resp_size), .up_resp_dstid(up_resp_dstid),
    .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready),
    .dn0_req_addr(dn0_req_addr), .dn0_req_wen(dn0_req_wen), .dn0_req_wdata(dn0_req_wdata),
    .dn0_req_wmask(dn0_req_wmask), .dn0_req_size(dn0_req_size), .dn0_req_srcid(dn0_req_srcid),
    .dn0_req_valid(dn0_req_valid), .dn0_req_ready(dn0_req_ready),
    .dn0_resp_rdata(dn0_resp_rdata), .dn0_resp_size(dn0_resp_size), .dn0_resp_dstid(dn0_resp_dstid),
    .dn0_resp_valid(dn0_resp_valid), .dn0_resp_ready(dn0_resp_ready),
    .dn1_req_addr(dn1_req_addr), .dn1_req_wen(dn1_req_wen), .dn1_req_wdata(dn1_req_wdata),
    .dn1_req_wmask(dn1_req_wmask), .dn1_req_size(dn1_req_size), .dn1_req_srcid(dn1_req_srcid),
    .dn1_req_valid(dn1_req_valid), .dn1_req_ready(dn1_req_ready),
    .dn1_resp_rdata(dn1_resp_rdata), .dn1_resp_size(dn1_resp_size), .dn1_resp_dstid(dn1_resp_dstid),
    .dn1_resp_valid(dn1_resp_valid), .dn1_resp_ready(dn1_resp_ready),
    .dbg_count(dbg_count), .dbg_wr_ptr(dbg_wr_ptr), .dbg_rd_ptr(dbg_rd_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [1:0]  m_wr;
  logic [1:0]  m_rd;
  logic [2:0]  m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: handshake did not complete within 20 cycles at %0t", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    up_req_addr = '0; up_req_wen = 1'b0; up_req_wdata = '0; up_req_wmask = '0;
    up_req_size = 3'd3; up_req_srcid = '0; up_req_valid = 1'b0; up_resp_ready = 1'b0;
    dn0_req_ready = 1'b1; dn1_req_ready = 1'b1;
    dn0_resp_rdata = '0; dn0_resp_size = 3'd3; dn0_resp_dstid = '0; dn0_resp_valid = 1'b0;
    dn1_resp_rdata = '0; dn1_resp_size = 3'd3; dn1_resp_dstid = '0; dn1_resp_valid = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_wr = '0; m_rd = '0; m_cnt = '0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts and ends on a falling edge; d is the data the target will later return.
  task automatic send_req(input logic [31:0] a, input logic w, input logic [7:0] m,
                          input logic [4:0] id, input logic port, input logic [63:0] d);
    logic ok;
    ok = 1'b0;
    up_req_addr = a; up_req_wen = w; up_req_wmask = m; up_req_srcid = id;
    up_req_wdata = {a, a}; up_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (up_req_ready) begin
        ok = 1'b1;
        chk("req_sel_valid", 64'(port ? dn1_req_valid : dn0_req_valid), 64'd1);
        chk("req_other_valid", 64'(port ? dn0_req_valid : dn1_req_valid), 64'd0);
        chk("req_srcid", 64'(port ? dn1_req_srcid : dn0_req_srcid), 64'(id));
        chk("req_wen_wmask", 64'(port ? {dn1_req_wen, dn1_req_wmask} : {dn0_req_wen, dn0_req_wmask}),
            64'({w, m}));
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("req_accept");
    else begin
      exp_q.push_back(d);
      m_wr++; m_cnt++;
    end
    #1;
    chk("count_after_push", 64'(dbg_count), 64'(m_cnt));
    chk("wr_ptr_after_push", 64'(dbg_wr_ptr), 64'(m_wr));
    @(negedge clk);
    up_req_valid = 1'b0;
  endtask

  // The given port returns the oldest scoreboard entry; starts/ends on a falling edge.
  task automatic take_resp(input logic port, input logic [4:0] id);
    logic        ok;
    logic [63:0] d;
    ok = 1'b0;
    d = exp_q.pop_front();
    if (port) begin
      dn1_resp_valid = 1'b1; dn1_resp_rdata = d; dn1_resp_dstid = id;
    end else begin
      dn0_resp_valid = 1'b1; dn0_resp_rdata = d; dn0_resp_dstid = id;
    end
    up_resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (up_resp_valid) begin
        ok = 1'b1;
        chk("resp_rdata", up_resp_rdata, d);
        chk("resp_dstid", 64'(up_resp_dstid), 64'(id));
        chk("resp_size", 64'(up_resp_size), 64'd3);
        chk("resp_port_ready", 64'(port ? dn1_resp_ready : dn0_resp_ready), 64'd1);
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("resp_return");
    else begin
      m_rd++; m_cnt--;
    end
    #1;
    chk("count_after_pop", 64'(dbg_count), 64'(m_cnt));
    chk("rd_ptr_after_pop", 64'(dbg_rd_ptr), 64'(m_rd));
    @(negedge clk);
    dn0_resp_valid = 1'b0; dn1_resp_valid = 1'b0; up_resp_ready = 1'b0;
  endtask

  // ---------------- routing vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        vld;
    logic        r0;
    logic        r1;
    logic        e_v0;
    logic        e_v1;
    logic        e_rdy;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vt[9];

  initial begin
    //        addr           vld   r0    r1    e_v0  e_v1  e_rdy e_cnt
    vt[0] = '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[1] = '{32'h0200_0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vt[2] = '{32'h02FF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1};
    vt[3] = '{32'h0300_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2};
    vt[4] = '{32'h01FF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
    vt[5] = '{32'h0200_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2};
    vt[6] = '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3};
    vt[7] = '{32'hFE00_0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4};
    vt[8] = '{32'h0200_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4};

    // reset state, checked with traffic pending on every input
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    up_req_valid = 1'b1; up_req_addr = 32'h8000_0000;
    dn0_resp_valid = 1'b1; up_resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 64'(dbg_count), 64'd0);
    chk("rst_up_req_ready", 64'(up_req_ready), 64'd0);
    chk("rst_dn0_req_valid", 64'(dn0_req_valid), 64'd0);
    chk("rst_up_resp_valid", 64'(up_resp_valid), 64'd0);
    chk("rst_dn0_resp_ready", 64'(dn0_resp_ready), 64'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      up_req_addr = vt[i].addr; up_req_valid = vt[i].vld;
      dn0_req_ready = vt[i].r0; dn1_req_ready = vt[i].r1;
      #1;
      chk($sformatf("vec%0d_dn0_valid", i), 64'(dn0_req_valid), 64'(vt[i].e_v0));
      chk($sformatf("vec%0d_dn1_valid", i), 64'(dn1_req_valid), 64'(vt[i].e_v1));
      chk($sformatf("vec%0d_up_ready", i), 64'(up_req_ready), 64'(vt[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), 64'(dbg_count), 64'(vt[i].e_cnt));
      @(negedge clk);
    end
    reset_pulse();

    // 1: read to the bridge window
    send_req(32'h8000_0000, 1'b0, 8'h00, 5'd1, 1'b0, 64'h1122_3344_5566_7788);
    take_resp(1'b0, 5'd1);

    // 2: write to the local window, dstid preserved
    send_req(32'h0200_0010, 1'b1, 8'h0F, 5'd3, 1'b1, 64'hCAFE_0000_0000_0002);
    take_resp(1'b1, 5'd3);

    // 3: ordering, dn1 answers first and must wait
    send_req(32'h8000_0000, 1'b0, 8'h00, 5'd4, 1'b0, 64'hAAAA_AAAA_0000_000A);
    send_req(32'h0200_0000, 1'b0, 8'h00, 5'd5, 1'b1, 64'hBBBB_BBBB_0000_000B);
    dn1_resp_valid = 1'b1; dn1_resp_rdata = exp_q[1]; dn1_resp_dstid = 5'd5;
    up_resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ord_dn1_held", 64'(dn1_resp_ready), 64'd0);
      chk("ord_up_valid_low", 64'(up_resp_valid), 64'd0);
      chk("ord_count_hold", 64'(dbg_count), 64'd2);
      @(negedge clk);
    end
    take_resp(1'b0, 5'd4);
    take_resp(1'b1, 5'd5);

    // 4: full blocks a fifth request, even alongside a pop
    for (int i = 0; i < 4; i++)
      send_req(32'h8000_0000, 1'b0, 8'h00, 5'(i), 1'b0, 64'hF000_0000_0000_0000 | 64'(i));
    up_req_addr = 32'h0200_0000; up_req_srcid = 5'd9; up_req_valid = 1'b1;
    #1;
    chk("full_up_ready", 64'(up_req_ready), 64'd0);
    chk("full_dn1_valid", 64'(dn1_req_valid), 64'd0);
    chk("full_dn0_valid", 64'(dn0_req_valid), 64'd0);
    dn0_resp_valid = 1'b1; dn0_resp_rdata = exp_q.pop_front(); dn0_resp_dstid = 5'd0;
    up_resp_ready = 1'b1;
    #1;
    chk("full_pop_up_ready", 64'(up_req_ready), 64'd0);
    chk("full_pop_resp_valid", 64'(up_resp_valid), 64'd1);
    chk("full_pop_rdata", up_resp_rdata, 64'hF000_0000_0000_0000);
    @(posedge clk);
    m_rd++; m_cnt--;
    @(negedge clk);
    dn0_resp_valid = 1'b0; up_resp_ready = 1'b0;
    #1;
    chk("after_pop_count", 64'(dbg_count), 64'd3);
    chk("after_pop_up_ready", 64'(up_req_ready), 64'd1);
    chk("after_pop_dn1_valid", 64'(dn1_req_valid), 64'd1);
    @(posedge clk);
    exp_q.push_back(64'hD000_0000_0000_0005);
    m_wr++; m_cnt++;
    @(negedge clk);
    up_req_valid = 1'b0;
    #1;
    chk("refill_count", 64'(dbg_count), 64'd4);
    @(negedge clk);
    for (int i = 1; i < 4; i++) take_resp(1'b0, 5'(i));
    take_resp(1'b1, 5'd9);

    // 5: upstream backpressure holds tracker state
    send_req(32'h8000_0000, 1'b0, 8'h00, 5'd7, 1'b0, 64'h5555_0000_0000_0005);
    dn0_resp_valid = 1'b1; dn0_resp_rdata = exp_q[0]; dn0_resp_dstid = 5'd7;
    up_resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_dn0_ready", 64'(dn0_resp_ready), 64'd0);
      chk("bp_count", 64'(dbg_count), 64'(m_cnt));
      chk("bp_rd_ptr", 64'(dbg_rd_ptr), 64'(m_rd));
      @(negedge clk);
    end
    take_resp(1'b0, 5'd7);

    // 6: async reset with two requests in flight
    send_req(32'h8000_0000, 1'b0, 8'h00, 5'd1, 1'b0, 64'h6);
    send_req(32'h0200_0000, 1'b0, 8'h00, 5'd2, 1'b1, 64'h7);
    #2;
    rst_n = 1'b0;
    up_req_valid = 1'b1; up_req_addr = 32'h8000_0000;
    dn0_resp_valid = 1'b1; up_resp_ready = 1'b1;
    #1;
    chk("arst_count", 64'(dbg_count), 64'd0);
    chk("arst_wr_ptr", 64'(dbg_wr_ptr), 64'd0);
    chk("arst_dn0_req_valid", 64'(dn0_req_valid), 64'd0);
    chk("arst_dn1_req_valid", 64'(dn1_req_valid), 64'd0);
    chk("arst_up_req_ready", 64'(up_req_ready), 64'd0);
    chk("arst_up_resp_valid", 64'(up_resp_valid), 64'd0);
    chk("arst_resp_readys", 64'({dn0_resp_ready, dn1_resp_ready}), 64'd0);
    model_clear();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    send_req(32'h0200_0008, 1'b0, 8'h00, 5'd6, 1'b1, 64'h0123_4567_89AB_CDEF);
    take_resp(1'b1, 5'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
